// File: rtl/pipelined_controller.sv
`timescale 1ns/1ps
// Prefetching program sequencer: fetches from a fixed-latency instruction port, retires one
// instruction per cycle, flushes on taken jumps and issues data requests over valid/ready.
module pipelined_controller #(
   parameter int INSTRUCTION_WIDTH = 32,
   parameter int INSTRUCTION_COUNT = 512,
   parameter int PRIVATE_REG_WIDTH = 16,
   parameter int DATA_ADDR_WIDTH   = 12,
   parameter int IMEM_LATENCY      = 2,
   parameter int PREFETCH_DEPTH    = 4,
   localparam int PW = $clog2(INSTRUCTION_COUNT)
) (
   input  logic                         clk_in,
   input  logic                         rst_in,
   input  logic                         start_in,
   output logic                         imem_en_out,
   output logic [PW-1:0]                imem_addr_out,
   input  logic [INSTRUCTION_WIDTH-1:0] imem_data_in,
   output logic                         mem_valid_out,
   input  logic                         mem_ready_in,
   output logic [1:0]                   mem_op_out,
   output logic [DATA_ADDR_WIDTH-1:0]   mem_addr_out,
   output logic [3:0]                   mem_word_out,
   output logic [15:0]                  mem_data_out,
   output logic                         busy_out,
   output logic                         done_out,
   output logic                         error_out,
   output logic [PW-1:0]                pc_out
);

   localparam int FW = PW + 1;
   localparam int BW = (PREFETCH_DEPTH > 1) ? $clog2(PREFETCH_DEPTH) : 1;
   localparam int CW = $clog2(PREFETCH_DEPTH + 1);
   localparam logic [FW-1:0] FETCH_END = FW'(INSTRUCTION_COUNT);

   // Opcode map; codes 10..15 are illegal and abort the program.
   typedef enum logic [3:0] {
      OP_NOP    = 4'd0,
      OP_END    = 4'd1,
      OP_XOR    = 4'd2,
      OP_ADDI   = 4'd3,
      OP_BGE    = 4'd4,
      OP_JUMP   = 4'd5,
      OP_SMA    = 4'd6,
      OP_LOADI  = 4'd7,
      OP_LOADB  = 4'd8,
      OP_WRITEB = 4'd9
   } opcode_t;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_MEM_WAIT} state_t;

   state_t state_q, state_d;

   logic [INSTRUCTION_WIDTH-1:0] fifo_mem [PREFETCH_DEPTH];
   logic [BW-1:0]                rd_ptr, wr_ptr;
   logic [CW-1:0]                occ;
   logic [IMEM_LATENCY-1:0]      req_vld_p, req_vld_next;
   logic [FW-1:0]                fetch_ptr;
   logic [PW-1:0]                head_pc;
   logic [PRIVATE_REG_WIDTH-1:0] regs [16];
   logic                         compare_reg;
   logic [DATA_ADDR_WIDTH-1:0]   addr_reg;

   logic [INSTRUCTION_WIDTH-1:0] head;
   logic [3:0]                   head_op, ra, rb;
   logic [15:0]                  imm;
   int                           inflight;
   logic                         exhausted, fetch_en, ret_vld, push, mem_fire;
   logic                         start_ok, pop, flush, jump_taken, err_set, done_set;
   logic                         mem_issue, reg_we, cmp_we, cmp_wd, sma_we;
   logic [3:0]                   reg_wa;
   logic [PRIVATE_REG_WIDTH-1:0] reg_wd;
   logic [1:0]                   mem_op_d;
   logic [DATA_ADDR_WIDTH-1:0]   mem_addr_d;
   logic [3:0]                   mem_word_d;
   logic [15:0]                  mem_data_d;
   logic                         unused_bits;

   function automatic logic [BW-1:0] ptr_inc(input logic [BW-1:0] p);
      return (p == BW'(PREFETCH_DEPTH - 1)) ? '0 : p + BW'(1);
   endfunction

   function automatic logic [PRIVATE_REG_WIDTH-1:0] add_mod(
      input logic [PRIVATE_REG_WIDTH-1:0] a,
      input logic [15:0]                  b
   );
      return a + PRIVATE_REG_WIDTH'(b);
   endfunction

   assign head        = fifo_mem[rd_ptr];
   assign head_op     = head[31:28];
   assign ra          = head[27:24];
   assign imm         = head[23:8];
   assign rb          = head[7:4];
   assign unused_bits = ^head[3:0];

   always_comb begin
      inflight = 0;
      for (int k = 0; k < IMEM_LATENCY; k++) inflight += int'(req_vld_p[k]);
   end

   assign exhausted   = (fetch_ptr >= FETCH_END);
   assign fetch_en    = (state_q != S_IDLE) && !flush && !exhausted &&
                        (int'(occ) + inflight < PREFETCH_DEPTH);
   assign ret_vld     = req_vld_p[IMEM_LATENCY-1];
   assign push        = ret_vld && !flush;
   assign mem_fire    = mem_valid_out && mem_ready_in;
   assign imem_en_out = fetch_en;
   assign imem_addr_out = fetch_ptr[PW-1:0];
   assign busy_out    = (state_q != S_IDLE);

   always_comb begin
      req_vld_next    = req_vld_p << 1;
      req_vld_next[0] = fetch_en;
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d    = state_q;
      start_ok   = 1'b0;
      pop        = 1'b0;
      flush      = 1'b0;
      jump_taken = 1'b0;
      err_set    = 1'b0;
      done_set   = 1'b0;
      mem_issue  = 1'b0;
      reg_we     = 1'b0;
      reg_wa     = '0;
      reg_wd     = '0;
      cmp_we     = 1'b0;
      cmp_wd     = 1'b0;
      sma_we     = 1'b0;
      mem_op_d   = 2'd0;
      mem_addr_d = '0;
      mem_word_d = '0;
      mem_data_d = '0;
      case (state_q)
         S_IDLE: begin
            // A start coinciding with the done pulse belongs to the finished run.
            if (start_in && !done_out) begin
               start_ok = 1'b1;
               state_d  = S_RUN;
            end
         end
         S_RUN: begin
            if (occ != '0) begin
               pop = 1'b1;
               case (head_op)
                  OP_NOP: begin end
                  OP_END: begin
                     flush    = 1'b1;
                     done_set = 1'b1;
                     state_d  = S_IDLE;
                  end
                  OP_XOR: begin
                     reg_we = 1'b1;
                     reg_wa = ra;
                     reg_wd = regs[ra] ^ regs[rb];
                  end
                  OP_ADDI: begin
                     reg_we = 1'b1;
                     reg_wa = ra;
                     reg_wd = add_mod(regs[rb], imm);
                  end
                  OP_BGE: begin
                     cmp_we = 1'b1;
                     cmp_wd = (regs[ra] >= regs[rb]);
                  end
                  OP_JUMP: begin
                     if (compare_reg) begin
                        flush      = 1'b1;
                        jump_taken = 1'b1;
                     end
                  end
                  OP_SMA: sma_we = 1'b1;
                  OP_LOADI: begin
                     mem_issue  = 1'b1;
                     mem_op_d   = 2'd0;
                     mem_addr_d = addr_reg;
                     mem_word_d = ra;
                     mem_data_d = imm;
                     state_d    = S_MEM_WAIT;
                  end
                  OP_LOADB: begin
                     mem_issue  = 1'b1;
                     mem_op_d   = 2'd1;
                     mem_addr_d = DATA_ADDR_WIDTH'(imm);
                     state_d    = S_MEM_WAIT;
                  end
                  OP_WRITEB: begin
                     mem_issue  = 1'b1;
                     mem_op_d   = 2'd2;
                     mem_addr_d = DATA_ADDR_WIDTH'(imm);
                     state_d    = S_MEM_WAIT;
                  end
                  default: begin
                     err_set = 1'b1;
                     flush   = 1'b1;
                     state_d = S_IDLE;
                  end
               endcase
            end else if (inflight == 0 && exhausted) begin
               err_set = 1'b1;
               state_d = S_IDLE;
            end
         end
         S_MEM_WAIT: begin
            if (mem_fire) state_d = S_RUN;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Fetch stage: in-flight tracking, prefetch buffer pointers, fetch/retire PCs.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         req_vld_p <= '0;
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         occ       <= '0;
         fetch_ptr <= '0;
         head_pc   <= '0;
         pc_out    <= '0;
      end else begin
         if (flush || start_ok) begin
            req_vld_p <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            occ       <= '0;
         end else begin
            req_vld_p <= req_vld_next;
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
               2'b10:   occ <= occ + CW'(1);
               2'b01:   occ <= occ - CW'(1);
               default: occ <= occ;
            endcase
         end
         if (start_ok) begin
            fetch_ptr <= '0;
            head_pc   <= '0;
         end else if (jump_taken) begin
            fetch_ptr <= {1'b0, imm[PW-1:0]};
            head_pc   <= imm[PW-1:0];
         end else begin
            if (fetch_en) fetch_ptr <= fetch_ptr + FW'(1);
            if (pop)      head_pc   <= head_pc + PW'(1);
         end
         if (pop) pc_out <= head_pc;
      end
   end

   always_ff @(posedge clk_in) begin
      if (push) fifo_mem[wr_ptr] <= imem_data_in;
   end

   // Execute stage: architectural registers and status flags.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         for (int i = 0; i < 16; i++) regs[i] <= '0;
         compare_reg <= 1'b0;
         addr_reg    <= '0;
         done_out    <= 1'b0;
         error_out   <= 1'b0;
      end else begin
         if (reg_we) regs[reg_wa] <= reg_wd;
         if (cmp_we) compare_reg <= cmp_wd;
         if (sma_we) addr_reg <= DATA_ADDR_WIDTH'(imm);
         done_out <= done_set;
         if (start_ok)     error_out <= 1'b0;
         else if (err_set) error_out <= 1'b1;
      end
   end

   // Memory request stage: fields are captured once and held until accepted.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         mem_valid_out <= 1'b0;
         mem_op_out    <= '0;
         mem_addr_out  <= '0;
         mem_word_out  <= '0;
         mem_data_out  <= '0;
      end else if (mem_issue) begin
         mem_valid_out <= 1'b1;
         mem_op_out    <= mem_op_d;
         mem_addr_out  <= mem_addr_d;
         mem_word_out  <= mem_word_d;
         mem_data_out  <= mem_data_d;
      end else if (mem_fire) begin
         mem_valid_out <= 1'b0;
      end
   end

endmodule

// File: doc/pipelined_controller.md
# pipelined_controller

Parametrised successor to the single-issue program controller. It fetches ISA instructions from an external instruction memory of configurable read latency into a prefetch buffer and retires one instruction per cycle in straight-line code. It flushes the buffer on taken jumps and issues data-cache / FMA-buffer requests over a valid/ready handshake. It sits between the program BRAM and the data cache, as the top-level sequencer of the GPU datapath.

## Interface
- INSTRUCTION_WIDTH, 32, instruction bits; fields MSB-first: op[31:28], ra[27:24], imm[23:8], rb[7:4], [3:0] unused
- INSTRUCTION_COUNT, 512, program depth; PC width PW = $clog2(INSTRUCTION_COUNT)
- PRIVATE_REG_WIDTH, 16, bits per private register (16 registers, fixed by the 4-bit fields)
- DATA_ADDR_WIDTH, 12, data-cache address bits
- IMEM_LATENCY, 2, cycles from address to data on the instruction port (≥1)
- PREFETCH_DEPTH, 4, prefetch buffer entries; must be ≥ IMEM_LATENCY+1
- clk_in  in  1  clock; single clock domain
- rst_in  in  1  asynchronous, active-high reset
- start_in  in  1  begin execution at PC 0; ignored while busy_out=1
- imem_en_out  out  1  instruction read request this cycle
- imem_addr_out  out  PW  instruction read address
- imem_data_in  in  INSTRUCTION_WIDTH  read data, valid IMEM_LATENCY cycles after the request cycle
- mem_valid_out  out  1  data request valid
- mem_ready_in  in  1  data request accepted
- mem_op_out  out  2  0 = LOADI, 1 = LOADB, 2 = WRITEB
- mem_addr_out  out  DATA_ADDR_WIDTH  target address
- mem_word_out  out  4  word index within the line (LOADI only, else 0)
- mem_data_out  out  16  immediate data (LOADI only, else 0)
- busy_out  out  1  high in RUN or MEM_WAIT
- done_out  out  1  one-cycle pulse, the cycle after END retires
- error_out  out  1  sticky; cleared by an accepted start_in
- pc_out  out  PW  address of the most recently retired instruction

## Operation
- States: IDLE, RUN, MEM_WAIT. Accepted start_in: IDLE→RUN, fetch pointer = 0, buffer empty, error_out cleared. Registers r0–r15 and compare_reg persist across starts and clear only on reset.
- Fetch: imem_en_out=1 in RUN/MEM_WAIT when occupancy + in-flight < PREFETCH_DEPTH and the fetch pointer has not passed INSTRUCTION_COUNT-1. There is no wrap. Returned words push at the end of their data cycle.
- Execute (RUN, buffer non-empty): pop the head and retire it in that cycle.
  - NOP: no effect.
  - END: flush, →IDLE, pulse done_out.
  - XOR: ra ^= rb.
  - ADDI: ra = rb + imm, modulo 2^PRIVATE_REG_WIDTH; imm is zero-extended or truncated to width.
  - BGE: compare_reg = (ra ≥ rb), unsigned.
  - JUMP: if compare_reg, flush the buffer, kill all in-flight returns, and set the fetch pointer to imm[PW-1:0]; otherwise fall through. compare_reg is unchanged.
  - SMA: addr_reg = imm[DATA_ADDR_WIDTH-1:0].
  - LOADI: request op 0, addr_reg, word = ra field, data = imm.
  - LOADB: request op 1, addr = imm.
  - WRITEB: request op 2, addr = imm.
  - Any other opcode: set error_out, flush, →IDLE, no done_out.
- Memory ops: RUN→MEM_WAIT. mem_* outputs are registered and held stable until mem_valid_out & mem_ready_in. mem_valid_out then drops, the op retires, and the state returns to RUN. Fetch continues during MEM_WAIT.
- Running off the end: if the buffer is empty, nothing is in flight, and the fetch pointer is exhausted without END, set error_out and go →IDLE.

## Timing
- Reset (asynchronous): state IDLE. All outputs 0, including mem_valid_out, which drops immediately even mid-handshake. Registers, compare_reg, addr_reg and the buffer are cleared; in-flight reads are discarded.
- start_in sampled at cycle s: address 0 issued at s+1, data at s+1+L, first retire at s+2+L (L = IMEM_LATENCY).
- Straight-line throughput: 1 instruction/cycle.
- Taken JUMP retiring at t: target address issued at t+1, target retires at t+2+L.
- Memory op retiring at t: mem_valid_out=1 from t+1. If ready is seen at cycle h, the next instruction retires no earlier than h+1.
- done_out is high exactly at cycle e+1, where END retired at e. busy_out is low from e+1.
- start_in while busy: ignored. start_in in the same cycle as done_out: ignored.

## Test plan
- Throughput (L=2, depth 4): program of 8 NOP then END, start at s → retires at s+4…s+11, END at s+12, done_out high only at s+13, imem_en_out never issued beyond address 8 + in-buffer slack.
- Loop: 0 ADDI r1,r0,#5; 1 ADDI r2,r2,#1; 2 BGE r1,r2; 3 JUMP #1; 4 END → r2=6 at done_out, JUMP taken exactly 5 times, each taken jump incurs L+1 bubble cycles.
- Handshake: SMA #0x123; LOADI ra=7,#0xBEEF with mem_ready_in held low 5 cycles → mem_valid_out high 6 cycles, outputs stable (op 0, addr 0x123, word 7, data 0xBEEF), next instruction retires the cycle after acceptance.
- Wrap/width: ADDI r3,r0,#0xFFFF then ADDI r3,r3,#1 → r3=0; XOR r3,r3 → 0.
- Errors: opcode 4'b1111 → error_out=1, IDLE, no done_out; program without END in INSTRUCTION_COUNT=8 → error_out after PC 7 retires; next start clears error_out.
- Async reset asserted during MEM_WAIT → mem_valid_out, busy_out and pc_out go 0 without a clock edge; a subsequent start executes from PC 0 with registers zeroed.
